// File: rtl/scandoubler_if.sv
// Video bundle between the 15 kHz core and the scandoubler, plus the doubled-rate
// output towards the OSD overlay.
// Streaming video with no valid/ready: every signal is sampled each clk_sys cycle,
// and pixel timing is recovered inside the scandoubler from its phase counters.
interface scandoubler_if #(
  parameter int COLOR_DEPTH = 6
);
  logic [1:0]             scanlines;
  logic                   hs_in;
  logic                   vs_in;
  logic [COLOR_DEPTH-1:0] r_in;
  logic [COLOR_DEPTH-1:0] g_in;
  logic [COLOR_DEPTH-1:0] b_in;
  logic                   hs_out;
  logic                   vs_out;
  logic [COLOR_DEPTH-1:0] r_out;
  logic [COLOR_DEPTH-1:0] g_out;
  logic [COLOR_DEPTH-1:0] b_out;

  modport master (
    output scanlines, hs_in, vs_in, r_in, g_in, b_in,
    input  hs_out, vs_out, r_out, g_out, b_out
  );

  modport slave (
    input  scanlines, hs_in, vs_in, r_in, g_in, b_in,
    output hs_out, vs_out, r_out, g_out, b_out
  );
endinterface

// File: rtl/scandoubler.sv
// Line doubler: buffers one 15 kHz input line per bank and replays the other bank twice
// at double pixel rate, optionally darkening the second replay to fake scanlines.
module scandoubler #(
  parameter int COLOR_DEPTH = 6,
  parameter int HCNT_WIDTH  = 10,
  parameter int CLK_DIV     = 4
) (
  input logic          clk_sys,
  input logic          rst_n,
  scandoubler_if.slave vid
);

  localparam int CW    = COLOR_DEPTH;
  localparam int PIXW  = 3 * CW;
  localparam int DEPTH = 2 << HCNT_WIDTH;
  localparam int IPW   = $clog2(CLK_DIV);
  localparam int OPW   = (CLK_DIV > 2) ? $clog2(CLK_DIV / 2) : 1;

  localparam logic [IPW-1:0]        IN_LAST  = IPW'(CLK_DIV - 1);
  localparam logic [IPW-1:0]        IN_ONE   = IPW'(1);
  localparam logic [OPW-1:0]        OUT_LAST = OPW'(CLK_DIV / 2 - 1);
  localparam logic [OPW-1:0]        OUT_ONE  = OPW'(1);
  localparam logic [HCNT_WIDTH-1:0] HMAX     = '1;
  localparam logic [HCNT_WIDTH-1:0] HONE     = HCNT_WIDTH'(1);

  logic [PIXW-1:0] line_buf [0:DEPTH-1];

  logic                  hs_d;
  logic [IPW-1:0]        in_phase;
  logic [HCNT_WIDTH-1:0] hcnt_in;
  logic [HCNT_WIDTH-1:0] line_len;
  logic                  bank;
  logic [HCNT_WIDTH-1:0] sync_cnt;
  logic [HCNT_WIDTH-1:0] sync_len;
  logic                  seen_one;
  logic                  line_valid;

  logic [OPW-1:0]        out_phase;
  logic [HCNT_WIDTH-1:0] hcnt_out;
  logic                  half;

  logic                  hs_q;
  logic                  vs_q;
  logic [CW-1:0]         r_q;
  logic [CW-1:0]         g_q;
  logic [CW-1:0]         b_q;

  logic                  hs_rise;
  logic                  hs_fall;
  logic                  sample;
  logic                  wr_en;
  logic                  out_adv;
  logic                  wrap;
  logic [PIXW-1:0]       rd_pix;

  assign hs_rise = vid.hs_in & ~hs_d;
  assign hs_fall = ~vid.hs_in & hs_d;
  // The line-start cycle only restarts the counters; the first pixel is taken one cycle later.
  assign sample  = (in_phase == '0) & ~hs_rise;
  assign wr_en   = sample & (hcnt_in != HMAX);
  assign out_adv = (out_phase == OUT_LAST);
  assign wrap    = out_adv & (line_len != '0) & (hcnt_out == line_len - HONE);
  assign rd_pix  = line_buf[{~bank, hcnt_out}];

  function automatic logic [CW-1:0] dim(input logic [CW-1:0] c, input logic [1:0] mode);
    logic [CW-1:0] res;
    res = c;
    case (mode)
      2'd1:    res = c - (c >> 2);
      2'd2:    res = c >> 1;
      2'd3:    res = c >> 2;
      default: res = c;
    endcase
    return res;
  endfunction

  // Write port: no reset, buffer contents survive rst_n.
  always_ff @(posedge clk_sys) begin
    if (wr_en) line_buf[{bank, hcnt_in}] <= {vid.r_in, vid.g_in, vid.b_in};
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      hs_d       <= 1'b0;
      in_phase   <= '0;
      hcnt_in    <= '0;
      line_len   <= '0;
      bank       <= 1'b0;
      sync_cnt   <= '0;
      sync_len   <= '0;
      seen_one   <= 1'b0;
      line_valid <= 1'b0;
      vs_q       <= 1'b0;
    end else begin
      hs_d <= vid.hs_in;
      if (hs_fall) sync_len <= sync_cnt;
      if (hs_rise) begin
        in_phase   <= '0;
        hcnt_in    <= '0;
        line_len   <= hcnt_in;
        bank       <= ~bank;
        vs_q       <= vid.vs_in;
        sync_cnt   <= '0;
        seen_one   <= 1'b1;
        line_valid <= line_valid | seen_one;
      end else begin
        in_phase <= (in_phase == IN_LAST) ? '0 : in_phase + IN_ONE;
        if (wr_en) hcnt_in <= hcnt_in + HONE;
        if (sample && vid.hs_in && sync_cnt != HMAX) sync_cnt <= sync_cnt + HONE;
      end
    end
  end

  // Replay counters; a new input line always restarts the first half, even on a natural wrap.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      out_phase <= '0;
      hcnt_out  <= '0;
      half      <= 1'b0;
    end else if (hs_rise) begin
      out_phase <= '0;
      hcnt_out  <= '0;
      half      <= 1'b0;
    end else if (out_adv) begin
      out_phase <= '0;
      if (wrap) begin
        hcnt_out <= '0;
        half     <= 1'b1;
      end else if (hcnt_out != HMAX) begin
        hcnt_out <= hcnt_out + HONE;
      end
    end else begin
      out_phase <= out_phase + OUT_ONE;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      hs_q <= (hcnt_out < sync_len);
      if (!line_valid) begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end else if (half) begin
        r_q <= dim(rd_pix[PIXW-1 -: CW], vid.scanlines);
        g_q <= dim(rd_pix[2*CW-1 -: CW], vid.scanlines);
        b_q <= dim(rd_pix[CW-1:0], vid.scanlines);
      end else begin
        r_q <= rd_pix[PIXW-1 -: CW];
        g_q <= rd_pix[2*CW-1 -: CW];
        b_q <= rd_pix[CW-1:0];
      end
    end
  end

  assign vid.hs_out = hs_q;
  assign vid.vs_out = vs_q;
  assign vid.r_out  = r_q;
  assign vid.g_out  = g_q;
  assign vid.b_out  = b_q;

endmodule
